// File: rtl/rom_arb_pkg.sv
// Shared types for the two-port ROM read arbiter: default widths, requester ids and read tags.
// Optional grant statistics are enabled with ROM_RD_ARBITER_STAT_EN (see rom_rd_arbiter).
package rom_arb_pkg;

  localparam int ROM_AW = 8;
  localparam int ROM_DW = 8;
  localparam int CNT_W  = 16;

  typedef enum logic {
    ID_P0 = 1'b0,
    ID_P1 = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, id: ID_P0};

  function automatic tag_t make_tag(input req_id_t id);
    return '{valid: 1'b1, id: id};
  endfunction

endpackage

// File: rtl/rom_rd_arbiter_if.sv
// Read-request bundle for one ROM requester: request/address in, ack/returned word out.
// Requesters use the master modport, the arbiter uses the slave modport.
interface rom_rd_if #(
  parameter int AW = rom_arb_pkg::ROM_AW,
  parameter int DW = rom_arb_pkg::ROM_DW
);

  logic          req;
  logic [AW-1:0] addr;
  logic          ack;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rvalid,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rvalid,
    output rdata
  );

endinterface

// File: rtl/rom_arb_tag_pipe.sv
// Fixed-depth shift register of read tags; the head entry lines up with the ROM word on rom_q.
// Synchronous active-low reset invalidates every in-flight tag.
module rom_arb_tag_pipe
  import rom_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  tag_t tag_in,
  output tag_t tag_head
);

  tag_t stage_q [DEPTH];
  tag_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = tag_in;
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= TAG_IDLE;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_head = stage_q[DEPTH-1];

endmodule

// File: rtl/rom_rd_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM between two requesters, with tagged returns.
// Define ROM_RD_ARBITER_STAT_EN to add per-port saturating grant counters and stat_clr.
module rom_rd_arbiter
  import rom_arb_pkg::*;
#(
  parameter int AW      = ROM_AW,
  parameter int DW      = ROM_DW,
  parameter int ROM_LAT = 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  rom_rd_if.slave       port0,
  rom_rd_if.slave       port1,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_q
`ifdef ROM_RD_ARBITER_STAT_EN
  ,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
`endif
);

  logic          grant0;
  logic          grant1;
  req_id_t       ptr_q,      ptr_d;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          rvalid0_q,  rvalid0_d;
  logic          rvalid1_q,  rvalid1_d;
  logic [DW-1:0] rdata0_q,   rdata0_d;
  logic [DW-1:0] rdata1_q,   rdata1_d;
  tag_t          tag_in;
  tag_t          tag_head;

  // ptr_q names the port that wins when both request; acks are forced low during reset.
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    ptr_d      = ptr_q;
    rom_addr_d = rom_addr_q;
    tag_in     = TAG_IDLE;
    if (sys_rst_n) begin
      if (port0.req && (!port1.req || ptr_q == ID_P0)) begin
        grant0 = 1'b1;
      end else if (port1.req) begin
        grant1 = 1'b1;
      end
    end
    if (grant0) begin
      ptr_d      = ID_P1;
      rom_addr_d = port0.addr;
      tag_in     = make_tag(ID_P0);
    end else if (grant1) begin
      ptr_d      = ID_P0;
      rom_addr_d = port1.addr;
      tag_in     = make_tag(ID_P1);
    end
  end

  always_comb begin
    rvalid0_d = tag_head.valid && (tag_head.id == ID_P0);
    rvalid1_d = tag_head.valid && (tag_head.id == ID_P1);
    rdata0_d  = rvalid0_d ? rom_q : rdata0_q;
    rdata1_d  = rvalid1_d ? rom_q : rdata1_q;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ptr_q      <= ID_P0;
      rom_addr_q <= '0;
      rvalid0_q  <= 1'b0;
      rvalid1_q  <= 1'b0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      rom_addr_q <= rom_addr_d;
      rvalid0_q  <= rvalid0_d;
      rvalid1_q  <= rvalid1_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  // One extra stage beyond the ROM latency covers the registered rom_addr.
  rom_arb_tag_pipe #(
    .DEPTH (ROM_LAT + 1)
  ) u_tag_pipe (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .tag_in    (tag_in),
    .tag_head  (tag_head)
  );

  assign port0.ack    = grant0;
  assign port1.ack    = grant1;
  assign port0.rvalid = rvalid0_q;
  assign port1.rvalid = rvalid1_q;
  assign port0.rdata  = rdata0_q;
  assign port1.rdata  = rdata1_q;
  assign rom_addr     = rom_addr_q;

`ifdef ROM_RD_ARBITER_STAT_EN
  logic [CNT_W-1:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [CNT_W-1:0] gnt_cnt1_q, gnt_cnt1_d;

  // Clear beats increment; counters stick at all-ones.
  always_comb begin
    gnt_cnt0_d = gnt_cnt0_q;
    gnt_cnt1_d = gnt_cnt1_q;
    if (stat_clr) begin
      gnt_cnt0_d = '0;
      gnt_cnt1_d = '0;
    end else begin
      if (grant0 && (gnt_cnt0_q != '1)) gnt_cnt0_d = gnt_cnt0_q + 1'b1;
      if (grant1 && (gnt_cnt1_q != '1)) gnt_cnt1_d = gnt_cnt1_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      gnt_cnt0_q <= '0;
      gnt_cnt1_q <= '0;
    end else begin
      gnt_cnt0_q <= gnt_cnt0_d;
      gnt_cnt1_q <= gnt_cnt1_d;
    end
  end

  assign gnt_cnt0 = gnt_cnt0_q;
  assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// Directed bench for rom_rd_arbiter with a behavioural ROM (ROM[a] = a*7 + 8'h19).
// With ROM_RD_ARBITER_STAT_EN defined the ROM runs at latency 2 and the grant counters are exercised.
module tb_rom_rd_arbiter;
  import rom_arb_pkg::*;

`ifdef ROM_RD_ARBITER_STAT_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic [7:0] rom_addr;
  logic [7:0] rom_q;
  logic [7:0] rom_q1;
  logic [7:0] rom_q2;
  int         errors = 0;
  int         checks = 0;

  logic [7:0] b2b_exp [8] = '{8'h19, 8'h20, 8'h27, 8'h2E, 8'h35, 8'h3C, 8'h43, 8'h4A};

  always #5 sys_clk = ~sys_clk;

  rom_rd_if #(.AW(8), .DW(8)) if0 ();
  rom_rd_if #(.AW(8), .DW(8)) if1 ();

`ifdef ROM_RD_ARBITER_STAT_EN
  logic        stat_clr;
  logic [15:0] gnt_cnt0;
  logic [15:0] gnt_cnt1;
  logic [7:0]  stat_exp [5] = '{8'hB9, 8'hC0, 8'hC7, 8'hCE, 8'hD5};
`endif

  rom_rd_arbiter #(
    .AW      (8),
    .DW      (8),
    .ROM_LAT (LAT)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .port0     (if0),
    .port1     (if1),
    .rom_addr  (rom_addr),
    .rom_q     (rom_q)
`ifdef ROM_RD_ARBITER_STAT_EN
    ,
    .stat_clr  (stat_clr),
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1)
`endif
  );

  function automatic logic [7:0] rom_fn(input logic [7:0] a);
    logic [7:0] r;
    r = a * 8'd7;
    r = r + 8'h19;
    return r;
  endfunction

  always @(posedge sys_clk) begin
    rom_q1 <= rom_fn(rom_addr);
    rom_q2 <= rom_q1;
  end
  assign rom_q = (LAT == 2) ? rom_q2 : rom_q1;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int  rv_cnt;
    int  k;
    bit  exp0;
    bit  exp1;

    if0.req = 1'b1;  if0.addr = 8'h77;
    if1.req = 1'b0;  if1.addr = 8'h00;
`ifdef ROM_RD_ARBITER_STAT_EN
    stat_clr = 1'b0;
`endif

    // Reset: ack forced low even with a request pending, outputs cleared.
    step();
    step();
    check_output("ack0_in_reset", if0.ack, 0);
    if0.req = 1'b0;
    step();
    check_output("rst_rvalid0", if0.rvalid, 0);
    check_output("rst_rvalid1", if1.rvalid, 0);
    check_output("rst_rdata0", if0.rdata, 0);
    check_output("rst_rdata1", if1.rdata, 0);
    check_output("rst_rom_addr", rom_addr, 0);
`ifdef ROM_RD_ARBITER_STAT_EN
    check_output("rst_cnt0", gnt_cnt0, 0);
    check_output("rst_cnt1", gnt_cnt1, 0);
`endif
    sys_rst_n = 1'b1;
    rv_cnt = 0;
    repeat (20) begin
      step();
      if (if0.rvalid || if1.rvalid) rv_cnt++;
    end
    check_output("idle_no_rvalid", 16'(rv_cnt), 0);

    // Port 0 alone reading address 5.
    if0.req = 1'b1; if0.addr = 8'h05;
    #1;
    check_output("p0_ack0", if0.ack, 1);
    check_output("p0_ack1", if1.ack, 0);
    step();
    if0.req = 1'b0;
    check_output("p0_rom_addr", rom_addr, 8'h05);
    for (int i = 1; i <= LAT + 3; i++) begin
      check_output("p0_rvalid0", if0.rvalid, 16'(i == LAT + 2));
      if (i == LAT + 2) check_output("p0_rdata0", if0.rdata, 8'h3C);
      step();
    end
    check_output("p0_rdata0_held", if0.rdata, 8'h3C);

    // Reset while a port 1 read is in flight: its return must be discarded.
    if1.req = 1'b1; if1.addr = 8'h33;
    #1;
    check_output("mid_ack1", if1.ack, 1);
    step();
    if1.req = 1'b0;
    sys_rst_n = 1'b0;
    step();
    step();
    sys_rst_n = 1'b1;
    check_output("mid_rdata0_cleared", if0.rdata, 0);
    check_output("mid_rom_addr_cleared", rom_addr, 0);
    rv_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (if0.rvalid || if1.rvalid) rv_cnt++;
      step();
    end
    check_output("mid_no_rvalid", 16'(rv_cnt), 0);
    check_output("mid_rdata1", if1.rdata, 0);

    // Both ports requesting from reset: strict alternation starting at port 0.
    if0.req = 1'b1; if0.addr = 8'h10;
    if1.req = 1'b1; if1.addr = 8'h20;
    #1;
    for (int i = 0; i <= LAT + 5; i++) begin
      if (i == 4) begin
        if0.req = 1'b0;
        if1.req = 1'b0;
      end
      if (i < 4) begin
        check_output("rr_ack0", if0.ack, 16'(i % 2 == 0));
        check_output("rr_ack1", if1.ack, 16'(i % 2 == 1));
      end
      k = i - LAT - 2;
      exp0 = (k >= 0) && (k < 4) && (k % 2 == 0);
      exp1 = (k >= 0) && (k < 4) && (k % 2 == 1);
      check_output("rr_rvalid0", if0.rvalid, 16'(exp0));
      check_output("rr_rvalid1", if1.rvalid, 16'(exp1));
      if (exp0) check_output("rr_rdata0", if0.rdata, 8'h89);
      if (exp1) check_output("rr_rdata1", if1.rdata, 8'hF9);
      step();
    end

    // Back-to-back port 1 reads of addresses 0..7.
    if1.req = 1'b1;
    for (int i = 0; i <= LAT + 10; i++) begin
      if (i < 8) if1.addr = 8'(i);
      else if1.req = 1'b0;
      #1;
      check_output("b2b_ack1", if1.ack, 16'(i < 8));
      k = i - LAT - 2;
      exp1 = (k >= 0) && (k < 8);
      check_output("b2b_rvalid1", if1.rvalid, 16'(exp1));
      check_output("b2b_rvalid0", if0.rvalid, 0);
      if (exp1) check_output("b2b_rdata1", if1.rdata, 16'(b2b_exp[k]));
      step();
    end

    // Port 0 wins once, then its second request loses to port 1 and is withdrawn.
    for (int i = 0; i <= LAT + 6; i++) begin
      if (i == 0) begin
        if0.req = 1'b1; if0.addr = 8'h40;
        if1.req = 1'b0;
      end else if (i == 1) begin
        if0.req = 1'b1; if0.addr = 8'h50;
        if1.req = 1'b1; if1.addr = 8'h41;
      end else begin
        if0.req = 1'b0;
        if1.req = 1'b0;
      end
      #1;
      check_output("wd_ack0", if0.ack, 16'(i == 0));
      check_output("wd_ack1", if1.ack, 16'(i == 1));
      check_output("wd_rvalid0", if0.rvalid, 16'(i == LAT + 2));
      check_output("wd_rvalid1", if1.rvalid, 16'(i == LAT + 3));
      if (i == LAT + 2) check_output("wd_rdata0", if0.rdata, 8'hD9);
      if (i == LAT + 3) check_output("wd_rdata1", if1.rdata, 8'hE0);
      step();
    end
    check_output("wd_rdata0_held", if0.rdata, 8'hD9);

`ifdef ROM_RD_ARBITER_STAT_EN
    // Grant counters: clear, count five port 0 reads, then clear against a grant.
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    check_output("st_clr_cnt0", gnt_cnt0, 0);
    check_output("st_clr_cnt1", gnt_cnt1, 0);
    for (int i = 0; i <= LAT + 7; i++) begin
      if (i < 5) begin
        if0.req = 1'b1; if0.addr = 8'h60 + 8'(i);
      end else begin
        if0.req = 1'b0;
      end
      #1;
      check_output("st_ack0", if0.ack, 16'(i < 5));
      k = i - LAT - 2;
      exp0 = (k >= 0) && (k < 5);
      check_output("st_rvalid0", if0.rvalid, 16'(exp0));
      if (exp0) check_output("st_rdata0", if0.rdata, 16'(stat_exp[k]));
      step();
    end
    check_output("st_cnt0", gnt_cnt0, 16'd5);
    check_output("st_cnt1", gnt_cnt1, 16'd0);
    stat_clr = 1'b1;
    if0.req = 1'b1; if0.addr = 8'h70;
    #1;
    check_output("st_clr_ack0", if0.ack, 1);
    step();
    stat_clr = 1'b0;
    if0.req = 1'b0;
    check_output("st_prio_cnt0", gnt_cnt0, 0);
    check_output("st_prio_cnt1", gnt_cnt1, 0);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rom_rd_arbiter.md
Name: rom_rd_arbiter

Overview:
- Shares one single-port synchronous ROM (rom_8x256 class, registered address, ROM_LAT-cycle read) between two read requesters, e.g. the display address sequencer (port 0) and a debug/dump reader (port 1).
- Round-robin arbitration issues at most one ROM read per cycle.
- Tags each in-flight read and routes the returned word back to its owner with a valid pulse.
- Sits between the requesters and the ROM instance; the ROM's address and q ports connect only to this block.

Parameters:
- AW, 8, ROM address width.
- DW, 8, ROM data width.
- ROM_LAT, 1, ROM clocks from address sampled to q valid (1 = unregistered q, 2 = registered q).

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  synchronous reset, active-low.
- req0  in  1  port 0 read request; held with addr0 stable until ack0.
- addr0  in  AW  port 0 read address.
- ack0  out  1  combinational; addr0 accepted this cycle.
- rvalid0  out  1  one-cycle pulse; rdata0 updated.
- rdata0  out  DW  port 0 read data, held between pulses.
- req1, addr1, ack1, rvalid1, rdata1: same as port 0, for port 1.
- rom_addr  out  AW  registered address to ROM.
- rom_q  in  DW  ROM output data.

Behaviour:
- One clock (sys_clk); reset is synchronous and active-low (sys_rst_n). All state updates on the sys_clk rising edge.
- Reset values:
  - ack0/ack1 = 0 (forced low while sys_rst_n = 0), rvalid0/1 = 0, rdata0/1 = 0, rom_addr = 0.
  - Priority pointer favours port 0.
  - Tag pipeline cleared (all entries invalid).
- Arbitration (combinational from req0, req1 and the registered pointer):
  - Only one req high: grant it.
  - Both high: grant the port not granted most recently; pointer = port 0 after reset.
  - Pointer updates only on a grant.
  - ackN = grantN. Exactly one or zero acks per cycle.
- Issue:
  - On a grant in cycle T, rom_addr <= addrN at the end of T, and a tag {valid=1, id=N} enters the tag pipeline.
  - With no grant, rom_addr holds its value and a tag {valid=0} enters.
- Tag pipeline: shift register of depth ROM_LAT+1, advancing every cycle.
- Return:
  - When the tag leaving the pipeline is valid with id N, rdataN <= rom_q and rvalidN <= 1; otherwise rvalidN <= 0.
- Latency: rvalidN is high exactly ROM_LAT+2 cycles after the ackN cycle (3 for ROM_LAT = 1).
- Throughput: one read per cycle; the requester must present the next address in the cycle after ack to sustain back-to-back reads.
- Requester rules:
  - req held high after ack is a new request using the current addr.
  - req dropped before ack withdraws the request; nothing is issued.
  - Order of returns per port equals order of acks.
- Simultaneous return and new grant to the same port: independent; both occur.
- Reset mid-operation: in-flight reads discarded, no rvalid for them, outputs return to reset values on the next edge.
- Address width: addresses pass unmodified; no wrap or arithmetic inside the block.

Optional Feature:
- Macro: ROM_RD_ARBITER_STAT_EN.
- Defined:
  - Adds outputs gnt_cnt0 and gnt_cnt1 (16 bits each) and input stat_clr.
  - Each counter increments on its port's ack, saturates at 16'hFFFF, and clears to 0 on reset or on stat_clr = 1.
  - stat_clr takes priority over increment in the same cycle.
- Undefined: the ports and counters do not exist; arbitration behaviour is identical.

Decomposition:
- Shared package rom_arb_pkg:
  - Default AW/DW constants.
  - Requester-id typedef (1 bit: ID_P0 = 0, ID_P1 = 1).
  - Tag typedef {valid, id}.
- Sub-module rom_arb_tag_pipe: parameterised-depth tag shift register with synchronous active-low reset. Outputs the head tag.

Test Plan:
- Reset then idle: all outputs 0 and no rvalid for 20 cycles. Reassert sys_rst_n=0 mid-stream -> rvalid0/1 stay 0 afterwards for pre-reset reads.
- Port 0 alone, addr0=8'h05, ROM[5]=8'h3C, ROM_LAT=1 -> ack0 in cycle T, rvalid0=1 with rdata0=8'h3C in cycle T+3, rdata0 held after.
- Both req high from reset with addr0=8'h10 and addr1=8'h20, held continuously:
  - Acks alternate p0, p1, p0, p1.
  - rvalid0/rvalid1 alternate with ROM[16h]/ROM[32h].
- Back-to-back port 1 reads of 8'h00..8'h07, address advanced on each ack -> 8 acks in 8 cycles, 8 consecutive rvalid1 pulses with ROM[0..7] in order.
- req0 pulsed one cycle while port 1 holds the grant (pointer favours port 1) -> no ack0 and no rvalid0.
- With ROM_RD_ARBITER_STAT_EN and ROM_LAT=2:
  - 5 port-0 reads -> gnt_cnt0=5, gnt_cnt1=0, rvalid0 occurs 4 cycles after each ack.
  - stat_clr=1 -> both counters 0.
